memcopy: RTL and testbench
==========================

# memcopy

Word-copy engine that masters one port of a dual-port block RAM. It moves `len` consecutive words from a source address range to a destination range using the RAM's one-cycle synchronous read. It sits directly upstream of the RAM wrapper's B port and drives its enable, write-enable, address and write data. It samples read data from the same port. It is used for boot-time image relocation and for bulk clears or copies commanded by a control register.

## Interface
Parameters:
- `PBITS`, 32: memory address width. Must match the RAM port address width.
- `DBITS`, 32: data word width.
- `LBITS`, 16: width of the length/count field.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a copy. Sampled only in IDLE.
- `src` input PBITS: first source word address. Sampled with `start`.
- `dst` input PBITS: first destination word address. Sampled with `start`.
- `len` input LBITS: number of words to copy. Sampled with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until the last write has issued.
- `done` output 1: one-cycle pulse when a copy completes.
- `mem_en` output 1: RAM port enable.
- `mem_we` output 1: RAM port write enable. Only meaningful with `mem_en`.
- `mem_addr` output PBITS: RAM port address.
- `mem_dout` output DBITS: write data to the RAM.
- `mem_din` input DBITS: read data from the RAM. Valid the cycle after a read is issued.

## Operation
- States: IDLE, READ, WAIT, WRITE, FINISH.
- IDLE:
  - All `mem_*` outputs are 0.
  - If `start` is 1 and `len` is nonzero: latch `src`, `dst` and `len`, clear the word index `i` to 0, go to READ.
  - If `start` is 1 and `len` is 0: go to FINISH with no memory traffic.
  - If `start` is 0: stay in IDLE.
- READ: drive `mem_en`=1, `mem_we`=0, `mem_addr`=`src`+`i`. Go to WAIT.
- WAIT: drive `mem_en`=0. At the clock edge, capture `mem_din` into the data buffer. Go to WRITE.
- WRITE:
  - Drive `mem_en`=1, `mem_we`=1, `mem_addr`=`dst`+`i`, `mem_dout`=buffer.
  - Increment `i`.
  - If the incremented `i` equals `len`, go to FINISH; otherwise go to READ.
- FINISH: assert `done` for exactly one cycle. Go to IDLE.
- Address arithmetic is modulo 2^PBITS. `src`+`i` and `dst`+`i` wrap silently past all-ones.
- `i` is LBITS wide. The maximum copy length is 2^LBITS−1 words.
- Copy order is strictly ascending.
- Overlapping ranges are not corrected:
  - With `dst` greater than `src` and overlapping, already-copied words are re-read. This is the defined behaviour, and it is used for pattern fill.
  - With `dst` equal to `src`, the copy rewrites the same values.
- A read from an address outside the RAM's range returns whatever is on the bus, including high-Z. The engine copies it unchanged and does not flag it.
- `start` while `busy` is ignored. It is not queued.
- `src`, `dst` and `len` may change freely after the cycle in which `start` is accepted.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `mem_en`, `mem_we` are 0.
  - `mem_addr`, `mem_dout`, the data buffer and `i` are 0.
- Reset mid-copy aborts immediately and asynchronously:
  - `mem_en` and `mem_we` drop without waiting for a clock edge.
  - A partially copied range is left as-is.
  - No `done` pulse is generated.
- `start` accepted at edge k:
  - The first READ is driven in cycle k+1.
  - Each word takes 3 cycles (READ, WAIT, WRITE).
  - For `len`=N, the last WRITE is in cycle k+3N.
  - FINISH, with `done`=1, is in cycle k+3N+1.
  - `busy`=0 again from cycle k+3N+1.
- `len`=0: `done`=1 in cycle k+1, and `busy` never rises.
- All outputs are registered state decodes. There is no combinational path from `mem_din` to any output.
- A new `start` can be accepted in the cycle after `done`, i.e. when IDLE is re-entered.

## Test plan
- Basic copy:
  - Stimulus: RAM words 0x10..0x13 preloaded with 0xA0..0xA3; `start` with `src`=0x10, `dst`=0x40, `len`=4.
  - Response: words 0x40..0x43 = 0xA0..0xA3; `done` 13 cycles after the accepting edge; source words unchanged.
- Zero length:
  - Stimulus: `len`=0, `start`=1.
  - Response: no `mem_en` activity; `done` pulse 1 cycle later; `busy` stays 0.
- Address wrap:
  - Stimulus: `src`=0xFFFFFFFE, `dst`=0x00000100, `len`=3.
  - Response: reads issued at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, in that order.
- Overlap fill:
  - Stimulus: word 0x20 = 0x55, `src`=0x20, `dst`=0x21, `len`=5.
  - Response: words 0x21..0x25 all = 0x55.
- Start ignored while busy:
  - Stimulus: second `start` pulse with different `src`/`dst` during a `len`=8 copy.
  - Response: only the original copy is performed, with a single `done` pulse.
- Reset mid-copy:
  - Stimulus: assert `reset` during the WRITE of word 2 of a `len`=6 copy.
  - Response: `mem_en`=0 in the same cycle; words 0..1 copied, words 3..5 untouched; no `done`; a subsequent `start` works normally.

Source files
------------

// File: rtl/memcopy.sv
`default_nettype none
// ============================================================================
// Module   : memcopy
// Brief    : Word-copy engine mastering one synchronous-read block-RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module memcopy #(
    parameter int PBITS = 32,
    parameter int DBITS = 32,
    parameter int LBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PBITS-1:0] src,
    input  logic [PBITS-1:0] dst,
    input  logic [LBITS-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic             mem_we,
    output logic [PBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_dout,
    input  logic [DBITS-1:0] mem_din
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [LBITS-1:0] c_idx_one = LBITS'(1);

    state_t           r_state;
    state_t           w_next;
    logic [PBITS-1:0] r_src;
    logic [PBITS-1:0] r_dst;
    logic [LBITS-1:0] r_len;
    logic [LBITS-1:0] r_idx;
    logic [DBITS-1:0] r_buf;
    logic [LBITS-1:0] w_idx_inc;
    logic [PBITS-1:0] w_offset;

    assign w_idx_inc = r_idx + c_idx_one;
    assign w_offset  = PBITS'(r_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operands are latched only on an accepted non-empty start, so later
    // changes on src/dst/len never disturb a copy in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src <= '0;
            r_dst <= '0;
            r_len <= '0;
            r_idx <= '0;
            r_buf <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (len != '0)) begin
                        r_src <= src;
                        r_dst <= dst;
                        r_len <= len;
                        r_idx <= '0;
                    end
                end
                S_WAIT:  r_buf <= mem_din;
                S_WRITE: r_idx <= w_idx_inc;
                default: ;
            endcase
        end
    end

    // Outputs decode the registered state only; mem_din never reaches a port.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_dout = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? S_READ : S_FINISH;
                end
            end
            S_READ: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = r_src + w_offset;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                busy   = 1'b1;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = r_dst + w_offset;
                mem_dout = r_buf;
                w_next   = (w_idx_inc == r_len) ? S_FINISH : S_READ;
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_memcopy.sv
`default_nettype none
// tb_memcopy: directed copy scenarios; a transaction-level copy model predicts
// the per-cycle bus activity and the final memory image.
module tb_memcopy;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, mem_en, mem_we;
    logic [31:0] mem_addr, mem_dout;
    logic [31:0] mem_din = '0;

    always #5 clk = ~clk;

    memcopy #(.PBITS(32), .DBITS(32), .LBITS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    // 4K-word RAM decoding the low 12 address bits; unwritten words read a
    // fixed background pattern.
    logic [31:0] ram     [4096];
    bit          vld     [4096];
    logic [31:0] ref_mem [4096];
    logic        pk_en = 1'b0;
    logic [31:0] pk_addr = '0;
    logic [31:0] pk_data = '0;

    function automatic logic [31:0] bg(input logic [31:0] a);
        return {20'h5A5A0, a[11:0]};
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return vld[a[11:0]] ? ram[a[11:0]] : bg(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr[11:0]] <= mem_dout;
            vld[mem_addr[11:0]] <= 1'b1;
        end else if (pk_en) begin
            ram[pk_addr[11:0]] <= pk_data;
            vld[pk_addr[11:0]] <= 1'b1;
        end
        if (mem_en && !mem_we) mem_din <= ram_rd(mem_addr);
    end

    typedef struct {
        logic        e_en, e_we, e_busy, e_done;
        logic [31:0] e_addr, e_dout;
        bit          c_we, c_addr, c_dout;
    } exp_t;

    exp_t        q[$];
    logic [31:0] rd_log[$];
    int n_checks = 0, n_pass = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0, n_done = 0;

    function automatic exp_t mk(input logic en, we, bsy, dn, input logic [31:0] ad, dt,
                                input bit cw, ca, cd);
        exp_t e;
        e.e_en = en; e.e_we = we; e.e_busy = bsy; e.e_done = dn;
        e.e_addr = ad; e.e_dout = dt; e.c_we = cw; e.c_addr = ca; e.c_dout = cd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Copy model: words move one at a time in ascending order, so overlap
    // re-reads earlier results; only the first napply words reach memory.
    task automatic expect_copy(input logic [31:0] s, d, input int n, input int napply);
        logic [31:0] a, b, v;
        if (n == 0) begin
            q.push_back(mk(0, 0, 0, 1, '0, '0, 0, 0, 0));
            return;
        end
        for (int j = 0; j < n; j++) begin
            a = s + 32'(j);
            b = d + 32'(j);
            v = ref_mem[a[11:0]];
            if (j < napply) ref_mem[b[11:0]] = v;
            q.push_back(mk(1, 0, 1, 0, a, '0, 1, 1, 0));
            q.push_back(mk(0, 0, 1, 0, '0, '0, 0, 0, 0));
            q.push_back(mk(1, 1, 1, 0, b, v, 1, 1, 1));
        end
        q.push_back(mk(0, 0, 0, 1, '0, '0, 0, 0, 0));
    endtask

    initial begin : compare
        exp_t e;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) e = q.pop_front();
            else e = mk(0, 0, 0, 0, '0, '0, 1, 1, 1);
            ok = (mem_en === e.e_en) && (busy === e.e_busy) && (done === e.e_done)
                 && (!e.c_we || (mem_we === e.e_we))
                 && (!e.c_addr || (mem_addr === e.e_addr))
                 && (!e.c_dout || (mem_dout === e.e_dout));
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL bus cycle %0d: en=%b we=%b addr=%h dout=%h busy=%b done=%b, want en=%b we=%b addr=%h dout=%h busy=%b done=%b",
                          cyc, mem_en, mem_we, mem_addr, mem_dout, busy, done,
                          e.e_en, e.e_we, e.e_addr, e.e_dout, e.e_busy, e.e_done);
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (mem_en === 1'b1 && mem_we === 1'b0) rd_log.push_back(mem_addr);
        end
    end

    task automatic poke(input logic [31:0] a, v);
        @(negedge clk);
        pk_en = 1'b1; pk_addr = a; pk_data = v;
        ref_mem[a[11:0]] = v;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] s, d, input logic [15:0] l, input int napply);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        expect_copy(s, d, int'(l), napply);
        @(posedge clk);
        acc_cyc = cyc;
        #2;
        start = 1'b0; src = 32'hDEAD0000; dst = 32'hBEEF0000; len = 16'h0007;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 2000 && q.size() != 0; c++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL wait_idle: %0d expected cycles left, want 0", q.size());
            q.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] wexp[3];
        for (int i = 0; i < 4096; i++) ref_mem[i] = bg(32'(i));

        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_en", 32'(mem_en), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic copy
        for (int i = 0; i < 4; i++) poke(32'h10 + 32'(i), 32'hA0 + 32'(i));
        n_done = 0;
        do_start(32'h10, 32'h40, 16'd4, 4);
        wait_idle();
        chk("basic done latency", 32'(done_cyc - acc_cyc), 32'd13);
        chk("basic done count", 32'(n_done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("basic dst word", ram_rd(32'h40 + 32'(i)), 32'hA0 + 32'(i));
            chk("basic src word", ram_rd(32'h10 + 32'(i)), 32'hA0 + 32'(i));
        end

        // Zero length
        n_done = 0;
        do_start(32'h10, 32'h40, 16'd0, 0);
        wait_idle();
        chk("zero done latency", 32'(done_cyc - acc_cyc), 32'd1);
        chk("zero done count", 32'(n_done), 32'd1);

        // Address wrap
        rd_log.delete();
        do_start(32'hFFFF_FFFE, 32'h100, 16'd3, 3);
        wait_idle();
        wexp[0] = 32'hFFFF_FFFE; wexp[1] = 32'hFFFF_FFFF; wexp[2] = 32'h0000_0000;
        chk("wrap read count", 32'(rd_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("wrap read addr", (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFF0, wexp[i]);
        chk("wrap dst0", ram_rd(32'h100), 32'h5A5A_0FFE);
        chk("wrap dst1", ram_rd(32'h101), 32'h5A5A_0FFF);
        chk("wrap dst2", ram_rd(32'h102), 32'h5A5A_0000);

        // Overlap fill
        poke(32'h20, 32'h55);
        do_start(32'h20, 32'h21, 16'd5, 5);
        wait_idle();
        for (int i = 1; i <= 5; i++) chk("overlap fill", ram_rd(32'h20 + 32'(i)), 32'h55);

        // Start ignored while busy
        for (int i = 0; i < 8; i++) poke(32'h60 + 32'(i), 32'hB0 + 32'(i));
        n_done = 0;
        do_start(32'h60, 32'h80, 16'd8, 8);
        repeat (4) @(negedge clk);
        start = 1'b1; src = 32'h200; dst = 32'h300; len = 16'd2;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("busy-start done count", 32'(n_done), 32'd1);
        chk("busy-start no write", ram_rd(32'h300), 32'h5A5A_0300);
        chk("busy-start last word", ram_rd(32'h87), 32'hB7);

        // Reset during the WRITE of word 2
        for (int i = 0; i < 6; i++) poke(32'h400 + 32'(i), 32'hC0 + 32'(i));
        n_done = 0;
        do_start(32'h400, 32'h500, 16'd6, 2);
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort mem_en", 32'(mem_en), 32'd0);
        chk("abort mem_we", 32'(mem_we), 32'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort no done", 32'(n_done), 32'd0);
        chk("abort word0", ram_rd(32'h500), 32'hC0);
        chk("abort word1", ram_rd(32'h501), 32'hC1);
        for (int i = 2; i < 6; i++)
            chk("abort untouched", ram_rd(32'h500 + 32'(i)), 32'h5A5A_0500 + 32'(i));

        do_start(32'h400, 32'h500, 16'd6, 6);
        wait_idle();
        for (int i = 0; i < 6; i++)
            chk("after abort copy", ram_rd(32'h500 + 32'(i)), 32'hC0 + 32'(i));

        for (int i = 0; i < 4096; i++)
            if (ram_rd(32'(i)) !== ref_mem[i]) chk("final image", ram_rd(32'(i)), ref_mem[i]);
        chk("final image word 0x25", ram_rd(32'h25), ref_mem[12'h025]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
